// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    localparam int LSU_ADDR_W    = 8;
    localparam int LSU_DATA_W    = 8;
    localparam int LSU_REG_IDX_W = 3;
    localparam int LSU_CNT_W     = 16;

endpackage

// File: rtl/lsu_sat_counter.sv
// 16-bit saturating event counter used for load/store statistics.
// Only built when LSU_STATS_EN is defined.
`ifdef LSU_STATS_EN
module lsu_sat_counter
    import lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [LSU_CNT_W-1:0] count
);

    // Count enabled events, holding at all-ones once reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {LSU_CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time from execute,
// drives the data memory strobes for one cycle and returns load data to
// writeback with a one-cycle valid pulse.
// Optional macro LSU_STATS_EN adds saturating load/store access counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = LSU_ADDR_W,
    parameter int DATA_W    = LSU_DATA_W,
    parameter int REG_IDX_W = LSU_REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_load,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [REG_IDX_W-1:0] req_rd,
    input  logic                 flush,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data
`ifdef LSU_STATS_EN
   ,output logic [LSU_CNT_W-1:0] load_count,
    output logic [LSU_CNT_W-1:0] store_count
`endif
);

    lsu_state_t state_q, state_d;

    logic                 req_is_load_q;
    logic [ADDR_W-1:0]    req_addr_q;
    logic [DATA_W-1:0]    req_wdata_q;
    logic [REG_IDX_W-1:0] req_rd_q;
    logic [REG_IDX_W-1:0] wb_rd_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic                 accept;

    assign accept = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flushed access always falls back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:   if (accept) state_d = LSU_ACCESS;
            LSU_ACCESS: state_d = (req_is_load_q && !flush) ? LSU_RESP : LSU_IDLE;
            LSU_RESP:   state_d = accept ? LSU_ACCESS : LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    // Handshake, strobes and writeback valid; reset forces them low without a clock
    always_comb begin
        req_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_valid  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                req_ready = !flush && !reset;
            end
            LSU_ACCESS: begin
                mem_read  = req_is_load_q && !flush && !reset;
                mem_write = !req_is_load_q && !flush && !reset;
            end
            LSU_RESP: begin
                req_ready = !flush && !reset;
                wb_valid  = !flush && !reset;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request capture on acceptance; these also feed the memory address/data pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_is_load_q <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_rd_q      <= '0;
        end else if (accept) begin
            req_is_load_q <= req_is_load;
            req_addr_q    <= req_addr;
            req_wdata_q   <= req_wdata;
            req_rd_q      <= req_rd;
        end
    end

    // Load result capture, only when the read strobe actually fired
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else if (mem_read) begin
            wb_rd_q   <= req_rd_q;
            wb_data_q <= mem_rdata;
        end
    end

    assign mem_addr  = req_addr_q;
    assign mem_wdata = req_wdata_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

`ifdef LSU_STATS_EN
    lsu_sat_counter u_load_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_read),
        .count (load_count)
    );

    lsu_sat_counter u_store_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_write),
        .count (store_count)
    );
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// random traffic, checked every cycle against a transaction-level model.
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_is_load;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [2:0] req_rd;
    logic       flush;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
`ifdef LSU_STATS_EN
    logic [15:0] load_count;
    logic [15:0] store_count;
`endif

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_is_load (req_is_load),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .flush       (flush),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
`ifdef LSU_STATS_EN
       ,.load_count  (load_count),
        .store_count (store_count)
`endif
    );

    // Environment data memory: combinational read, write on clock edge
    logic [7:0] mem_arr [256];
    logic       mem_init;
    assign mem_rdata = mem_arr[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_write) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
    end

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the access in flight this cycle, a pending response,
    // last accepted address/data and last delivered load result
    logic [7:0]  ref_mem [256];
    logic        acc_on, acc_load, resp_on, last_acc;
    logic [7:0]  acc_addr, acc_wdata, m_data;
    logic [2:0]  acc_rd, m_rd;
    int          n_loads, n_stores;

    task automatic model_reset();
        acc_on = 0; acc_load = 0; resp_on = 0; last_acc = 0;
        acc_addr = 0; acc_wdata = 0; acc_rd = 0; m_rd = 0; m_data = 0;
        n_loads = 0; n_stores = 0;
    endtask

    // Called just after a rising edge: drive inputs, check mid-cycle, advance model
    task automatic step(input logic v, input logic ld, input logic [7:0] a,
                        input logic [7:0] w, input logic [2:0] r, input logic f);
        logic e_ready, e_read, e_write, e_wbv, resp_next;
        req_valid = v; req_is_load = ld; req_addr = a; req_wdata = w; req_rd = r; flush = f;
        @(negedge clk);
        e_ready = !acc_on && !f;
        e_read  = acc_on && acc_load && !f;
        e_write = acc_on && !acc_load && !f;
        e_wbv   = resp_on && !f;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("mem_read",  32'(mem_read),  32'(e_read));
        chk("mem_write", 32'(mem_write), 32'(e_write));
        chk("mem_addr",  32'(mem_addr),  32'(acc_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(acc_wdata));
        chk("wb_valid",  32'(wb_valid),  32'(e_wbv));
        chk("wb_rd",     32'(wb_rd),     32'(m_rd));
        chk("wb_data",   32'(wb_data),   32'(m_data));
`ifdef LSU_STATS_EN
        chk("load_count",  32'(load_count),  32'(n_loads));
        chk("store_count", 32'(store_count), 32'(n_stores));
`endif
        resp_next = 0;
        if (e_read) begin
            m_rd = acc_rd;
            m_data = ref_mem[acc_addr];
            resp_next = 1;
            if (n_loads < 65535) n_loads++;
        end
        if (e_write) begin
            ref_mem[acc_addr] = acc_wdata;
            if (n_stores < 65535) n_stores++;
        end
        last_acc = v && e_ready;
        resp_on = resp_next;
        acc_on = last_acc;
        if (last_acc) begin
            acc_load = ld; acc_addr = a; acc_wdata = w; acc_rd = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, $urandom_range(0, 1), 8'($urandom), 8'($urandom), 3'($urandom), 0);
    endtask

    // Hold a request valid until the model sees it accepted
    task automatic issue(input logic ld, input logic [7:0] a, input logic [7:0] w, input logic [2:0] r);
        logic done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            step(1, ld, a, w, r, 0);
            done = last_acc;
        end
        if (!done) chk("issue_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1; mem_init = 1;
        req_valid = 0; req_is_load = 0; req_addr = 0; req_wdata = 0; req_rd = 0; flush = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        model_reset();
        #2;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_mem_read",  32'(mem_read),  0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr",  32'(mem_addr),  0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_wb_valid",  32'(wb_valid),  0);
        chk("rst_wb_rd",     32'(wb_rd),     0);
        chk("rst_wb_data",   32'(wb_data),   0);
        @(posedge clk); #1;
        mem_init = 0; reset = 0;

        // Single store then a load reading it back
        issue(0, 8'h10, 8'hA5, 3'd0);
        idle(2);
        issue(1, 8'h10, 8'h00, 3'd3);
        idle(1);
        chk("ld_wb_data", 32'(wb_data), 32'hA5);
        chk("ld_wb_rd",   32'(wb_rd),   32'd3);
        idle(2);

        // Seed three locations, then back-to-back loads with valid held high
        issue(0, 8'h00, 8'h11, 3'd0); idle(1);
        issue(0, 8'h01, 8'h22, 3'd0); idle(1);
        issue(0, 8'hFF, 8'h33, 3'd0); idle(1);
        issue(1, 8'h00, 8'h00, 3'd1);
        issue(1, 8'h01, 8'h00, 3'd2);
        chk("b2b_wb0", 32'(wb_data), 32'h11);
        issue(1, 8'hFF, 8'h00, 3'd7);
        chk("b2b_wb1", 32'(wb_data), 32'h22);
        idle(3);
        chk("b2b_wb2", 32'(wb_data), 32'h33);

        // Store flushed during its access never reaches memory
        issue(0, 8'h40, 8'h7E, 3'd0);
        step(0, 0, 8'h00, 8'h00, 3'd0, 1);
        idle(2);
        chk("flush_mem40", 32'(mem_arr[8'h40]), 32'(8'h40 ^ 8'h5A));

        // Reset asserted in the middle of a load's access cycle
        issue(1, 8'h22, 8'h00, 3'd5);
        req_valid = 0;
        chk("rst_mid_pre_read", 32'(mem_read), 32'd1);
        #1 reset = 1;
        #1;
        chk("rst_mid_read",  32'(mem_read),  0);
        chk("rst_mid_wbv",   32'(wb_valid),  0);
        chk("rst_mid_addr",  32'(mem_addr),  0);
        chk("rst_mid_wdata", 32'(mem_wdata), 0);
        chk("rst_mid_wbd",   32'(wb_data),   0);
        model_reset();
        @(posedge clk); #2;
        reset = 0;
        idle(3);

        // Random traffic including occasional flushes
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), 8'($urandom),
                 8'($urandom), 3'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(3);

        for (int i = 0; i < 256; i++) chk("mem_final", 32'(mem_arr[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequences single load/store requests from the execute stage into the data memory, one access at a time.
- Registers each accepted request and drives the memory's read/write strobes, address and write value for exactly one cycle.
- Captures the memory's combinational read value and presents it to register writeback with a one-cycle valid pulse.
- Sits directly upstream of data_memory (mem_addr→r_a, mem_wdata→r_b, data_out→mem_rdata).

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, data width
REG_IDX_W, 3, destination register index width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous reset, active-high
req_valid  in  1  execute stage presents a memory request
req_ready  out  1  unit can accept a request this cycle
req_is_load  in  1  1 = load, 0 = store
req_addr  in  ADDR_W  access address
req_wdata  in  DATA_W  store value (ignored for loads)
req_rd  in  REG_IDX_W  load destination register (ignored for stores)
flush  in  1  squash any in-flight or offered request
mem_read  out  1  read strobe to data memory
mem_write  out  1  write strobe to data memory
mem_addr  out  ADDR_W  address to data memory
mem_wdata  out  DATA_W  write value to data memory
mem_rdata  in  DATA_W  combinational read value from data memory
wb_valid  out  1  one-cycle pulse: load result available
wb_rd  out  REG_IDX_W  load destination register
wb_data  out  DATA_W  load result

Behaviour:
- Reset (async, active-high): state LSU_IDLE; all registers zero.
  - req_ready=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0.
  - Outputs take reset values immediately, without waiting for a clock edge.
- FSM states: LSU_IDLE, LSU_ACCESS, LSU_RESP.
- req_ready = (state==LSU_IDLE || state==LSU_RESP) && !flush && !reset.
- Accept: req_valid && req_ready at a rising edge.
  - Latches is_load, addr, wdata and rd into request registers.
  - Next state is LSU_ACCESS.
- LSU_ACCESS (exactly one cycle):
  - mem_addr and mem_wdata are driven from the request registers.
  - mem_read = is_load && !flush; mem_write = !is_load && !flush.
  - mem_read and mem_write are never both 1.
  - Load: mem_rdata is sampled into wb_data and rd into wb_rd at the closing edge. Next state LSU_RESP, or LSU_IDLE if flush.
  - Store: next state LSU_IDLE; no writeback.
- LSU_RESP (one cycle): wb_valid = !flush.
  - If a request is accepted in this cycle, next state is LSU_ACCESS; otherwise LSU_IDLE.
- Latency:
  - Load accepted at edge T: mem_read high in cycle T..T+1; wb_valid high in cycle T+1..T+2.
  - Store accepted at edge T: mem_write high in cycle T..T+1.
- Throughput: one request per 2 cycles, for loads and stores alike. Back-to-back loads are accepted in LSU_RESP.
- mem_addr, mem_wdata, wb_rd and wb_data hold their last values outside the states that update them.
- wb_valid is 0 in all states except LSU_RESP.
- Flush:
  - In LSU_IDLE/LSU_RESP it blocks acceptance.
  - In LSU_ACCESS it suppresses both strobes and returns to LSU_IDLE.
  - In LSU_RESP it suppresses wb_valid.
  - A flushed store never writes memory.
- Reset mid-operation: strobes and wb_valid drop asynchronously; the pending access is lost; no writeback follows.
- Addresses span the full 2^ADDR_W range; there are no range errors and no wrap logic.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined: adds output ports load_count[15:0] and store_count[15:0].
  - Each counter increments on every LSU_ACCESS cycle whose strobe actually asserts (flushed accesses are not counted).
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: no counter ports and no counter logic; all other behaviour is identical.

Decomposition:
- Package lsu_pkg:
  - Enum lsu_state_t {LSU_IDLE, LSU_ACCESS, LSU_RESP}.
  - Default width constants LSU_ADDR_W=8, LSU_DATA_W=8, LSU_REG_IDX_W=3.
- No sub-module required in the base block.
- Under LSU_STATS_EN, the counter is a natural sub-module, lsu_sat_counter (16-bit, increment enable, saturating, async active-high reset), instantiated twice.

Test Plan:
- Reset, then store addr 0x10 data 0xA5 → next cycle mem_write=1, mem_addr=0x10, mem_wdata=0xA5 for one cycle; mem_read=0; wb_valid never asserts.
- Load addr 0x10 rd=3, memory model returns 0xA5 → mem_read one cycle after accept, then wb_valid=1 for one cycle with wb_rd=3, wb_data=0xA5.
- Loads to 0x00, 0x01, 0xFF with req_valid held high (model data 0x11/0x22/0x33) → accepted every 2 cycles; wb_data sequence 0x11, 0x22, 0x33; req_ready high in each LSU_RESP.
- Store 0x40←0x7E with flush asserted during its LSU_ACCESS cycle → mem_write stays 0; state LSU_IDLE; req_ready=1 the following cycle; memory at 0x40 unchanged.
- Assert reset mid-cycle during a load's LSU_ACCESS → mem_read falls before the next edge; after release all outputs are zero and wb_valid never pulses for that load.
- With LSU_STATS_EN: preload store_count near 0xFFFF via 0xFFFF stores, then one more store → store_count stays 0xFFFF; load_count unaffected; a flushed load leaves load_count unchanged.
